// File: rtl/spi_regfile_rw.sv
// spi_regfile_rw: mode-0 SPI target exposing a bank of read/write configuration registers.
// SPI pins are oversampled on m_clk through synchronisers; all state lives in the m_clk domain.
module spi_regfile_rw #(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         m_clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         mosi,
  input  logic                         cs_n,
  output logic                         miso,
  output logic                         miso_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam int unsigned SET_W   = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0] CNT_LAST_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME     = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_SHIFT_MIN = CNT_W'(ADDR_W + 2);
  localparam logic [SET_W-1:0] SET_DONE      = SET_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_q, cs_q;
  logic [SET_W-1:0]       settle_cnt;
  logic                   settled;
  logic                   sclk_rise_p, sclk_fall_p, cs_rise_p, cs_fall_p, mosi_p;

  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_W-1:0]     rx, rx_nxt;
  logic [DATA_W-1:0]      tx;
  logic                   oe_flag;

  logic [ADDR_W-1:0]      rd_addr, wr_addr;
  logic [DATA_W-1:0]      rd_data, wr_data;
  logic [NUM_REGS-1:0]    wr_hit;
  logic                   commit_c, err_c, load_tx_c;

  // Edges that reach the sync output before the chain has flushed after reset are stale and masked.
  assign settled = (settle_cnt == SET_DONE);

  // Pin synchronisers plus registered edge pulses aligned with the sampled mosi bit.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      sclk_sync   <= '0;
      mosi_sync   <= '0;
      cs_sync     <= '1;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      settle_cnt  <= '0;
      sclk_rise_p <= 1'b0;
      sclk_fall_p <= 1'b0;
      cs_rise_p   <= 1'b0;
      cs_fall_p   <= 1'b0;
      mosi_p      <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_q      <= sclk_sync[SYNC_STAGES-1];
      cs_q        <= cs_sync[SYNC_STAGES-1];
      if (!settled) settle_cnt <= settle_cnt + SET_W'(1);
      sclk_rise_p <= settled &  sclk_sync[SYNC_STAGES-1] & ~sclk_q;
      sclk_fall_p <= settled & ~sclk_sync[SYNC_STAGES-1] &  sclk_q;
      cs_rise_p   <= settled &  cs_sync[SYNC_STAGES-1]   & ~cs_q;
      cs_fall_p   <= settled & ~cs_sync[SYNC_STAGES-1]   &  cs_q;
      mosi_p      <= mosi_sync[SYNC_STAGES-1];
    end
  end

  // Frame field extraction: read address on the fly, write fields from the completed frame.
  assign rx_nxt  = {rx[FRAME_W-2:0], mosi_p};
  assign rd_addr = rx_nxt[ADDR_W-1:0];
  assign wr_addr = rx[FRAME_W-2 -: ADDR_W];
  assign wr_data = rx[DATA_W-1:0];

  // Register decode; out-of-range addresses hit nothing and read as zero.
  always_comb begin
    rd_data = '0;
    wr_hit  = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs[i*DATA_W +: DATA_W];
      if (wr_addr == ADDR_W'(i)) wr_hit[i] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and frame-level decisions; cs rise beats cs fall beats sclk.
  always_comb begin
    state_nxt = state;
    commit_c  = 1'b0;
    err_c     = 1'b0;
    load_tx_c = 1'b0;
    if (cs_rise_p) begin
      state_nxt = ST_IDLE;
      if (state != ST_IDLE) begin
        commit_c = (bit_cnt == CNT_FRAME) && rx[FRAME_W-1];
        err_c    = (bit_cnt != CNT_FRAME) && (bit_cnt != '0);
      end
    end else if (cs_fall_p) begin
      if (state == ST_IDLE) state_nxt = ST_ADDR;
    end else if (sclk_rise_p && (state == ST_ADDR) && (bit_cnt == CNT_LAST_ADDR)) begin
      state_nxt = ST_DATA;
      load_tx_c = ~rx_nxt[ADDR_W];
    end
  end

  // Datapath: bit counter, shift registers, register bank and registered outputs.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      oe_flag   <= 1'b0;
      regs      <= '0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      wr_strobe <= commit_c ? wr_hit : '0;
      frame_err <= err_c;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (commit_c && wr_hit[i]) regs[i*DATA_W +: DATA_W] <= wr_data;
      end
      if (cs_rise_p) begin
        oe_flag <= 1'b0;
      end else if (cs_fall_p) begin
        if (state == ST_IDLE) begin
          bit_cnt <= '0;
          rx      <= '0;
          tx      <= '0;
          oe_flag <= 1'b0;
        end
      end else if (sclk_rise_p && (state != ST_IDLE)) begin
        if (bit_cnt != CNT_SAT)  bit_cnt <= bit_cnt + CNT_W'(1);
        if (bit_cnt < CNT_FRAME) rx      <= rx_nxt;
        if (load_tx_c) begin
          tx      <= rd_data;
          oe_flag <= 1'b1;
        end
      end else if (sclk_fall_p && (state != ST_IDLE) && (bit_cnt >= CNT_SHIFT_MIN)) begin
        tx <= tx << 1;
      end
      miso_oe <= oe_flag;
      miso    <= oe_flag & tx[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Directed bench for spi_regfile_rw: default instance plus a wide-parameter instance.
module tb_spi_regfile_rw;

  localparam int unsigned A_NR = 5,  A_AW = 7, A_DW = 8,  A_SS = 2;
  localparam int unsigned B_NR = 16, B_AW = 4, B_DW = 16, B_SS = 3;
  localparam int HALF = 6;

  logic m_clk = 1'b0;
  logic rst   = 1'b1;
  logic sclk  = 1'b0;
  logic mosi  = 1'b0;
  logic cs_a_n = 1'b1;
  logic cs_b_n = 1'b1;

  logic                    miso_a, miso_oe_a, frame_err_a;
  logic [A_NR*A_DW-1:0]    regs_a;
  logic [A_NR-1:0]         wr_strobe_a;
  logic                    miso_b, miso_oe_b, frame_err_b;
  logic [B_NR*B_DW-1:0]    regs_b;
  logic [B_NR-1:0]         wr_strobe_b;

  spi_regfile_rw #(.NUM_REGS(A_NR), .ADDR_W(A_AW), .DATA_W(A_DW), .SYNC_STAGES(A_SS)) u_dut_a (
    .m_clk(m_clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_a_n),
    .miso(miso_a), .miso_oe(miso_oe_a), .regs(regs_a), .wr_strobe(wr_strobe_a),
    .frame_err(frame_err_a)
  );

  spi_regfile_rw #(.NUM_REGS(B_NR), .ADDR_W(B_AW), .DATA_W(B_DW), .SYNC_STAGES(B_SS)) u_dut_b (
    .m_clk(m_clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_b_n),
    .miso(miso_b), .miso_oe(miso_oe_b), .regs(regs_b), .wr_strobe(wr_strobe_b),
    .frame_err(frame_err_b)
  );

  always #5 m_clk = ~m_clk;

  int checks = 0;
  int errors = 0;
  int stb_cnt_a = 0, err_cnt_a = 0, stb_cnt_b = 0, err_cnt_b = 0;
  logic [A_NR-1:0] stb_last_a = '0;
  logic [B_NR-1:0] stb_last_b = '0;
  logic [31:0] miso_cap, oe_cap;
  int s_stb, s_err;

  // Pulse monitors: count high cycles of the one-cycle strobes.
  always @(negedge m_clk) begin
    if (|wr_strobe_a) begin stb_cnt_a++; stb_last_a = wr_strobe_a; end
    if (frame_err_a)  err_cnt_a++;
    if (|wr_strobe_b) begin stb_cnt_b++; stb_last_b = wr_strobe_b; end
    if (frame_err_b)  err_cnt_b++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge m_clk);
  endtask

  // Clock out nbits MSB first; capture miso/miso_oe just before each rising sclk edge.
  task automatic clock_bits(input logic [31:0] bits, input int nbits, input bit to_b);
    for (int k = nbits - 1; k >= 0; k--) begin
      mosi = bits[k];
      wait_cyc(HALF);
      miso_cap = {miso_cap[30:0], (to_b ? miso_b : miso_a)};
      oe_cap   = {oe_cap[30:0], (to_b ? miso_oe_b : miso_oe_a)};
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] bits, input int nbits, input bit to_b);
    miso_cap = '0;
    oe_cap   = '0;
    s_stb = to_b ? stb_cnt_b : stb_cnt_a;
    s_err = to_b ? err_cnt_b : err_cnt_a;
    if (to_b) cs_b_n = 1'b0; else cs_a_n = 1'b0;
    wait_cyc(HALF);
    clock_bits(bits, nbits, to_b);
    wait_cyc(HALF);
    cs_a_n = 1'b1;
    cs_b_n = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  initial begin
    // Power-on reset
    wait_cyc(4);
    check("por_regs_a", 256'(regs_a), 256'h0);
    check("por_oe_a", 256'(miso_oe_a), 256'h0);
    check("por_miso_a", 256'(miso_a), 256'h0);
    check("por_strobe_a", 256'(wr_strobe_a), 256'h0);
    check("por_ferr_a", 256'(frame_err_a), 256'h0);
    check("por_regs_b", 256'(regs_b), 256'h0);
    rst = 1'b0;
    wait_cyc(6);

    // First write, then reset mid-idle
    frame(32'h81A5, 16, 1'b0);
    check("w1_regs", 256'(regs_a), 256'h00000_0A500);
    rst = 1'b1;
    wait_cyc(3);
    check("idle_rst_regs", 256'(regs_a), 256'h0);
    check("idle_rst_oe", 256'(miso_oe_a), 256'h0);
    rst = 1'b0;
    wait_cyc(6);

    // Write reg1 after reset
    frame(32'h81A5, 16, 1'b0);
    check("w_reg1_regs", 256'(regs_a), 256'h00000_0A500);
    check("w_reg1_nstb", 256'(stb_cnt_a - s_stb), 256'd1);
    check("w_reg1_stb", 256'(stb_last_a), 256'b00010);
    check("w_reg1_ferr", 256'(err_cnt_a - s_err), 256'd0);

    // Preload reg3 and read it back
    frame(32'h833C, 16, 1'b0);
    check("w_reg3_regs", 256'(regs_a), 256'h003C00A500);
    frame(32'h0300, 16, 1'b0);
    check("rd3_miso", 256'(miso_cap), 256'h003C);
    check("rd3_oe", 256'(oe_cap), 256'h00FF);
    check("rd3_regs", 256'(regs_a), 256'h003C00A500);
    check("rd3_nstb", 256'(stb_cnt_a - s_stb), 256'd0);
    check("rd3_ferr", 256'(err_cnt_a - s_err), 256'd0);
    check("rd3_oe_after", 256'(miso_oe_a), 256'h0);
    check("rd3_miso_after", 256'(miso_a), 256'h0);

    // Short and long write frames to reg0
    frame(32'h402A, 15, 1'b0);
    check("short_regs", 256'(regs_a), 256'h003C00A500);
    check("short_ferr", 256'(err_cnt_a - s_err), 256'd1);
    check("short_nstb", 256'(stb_cnt_a - s_stb), 256'd0);
    frame(32'h100AB, 17, 1'b0);
    check("long_regs", 256'(regs_a), 256'h003C00A500);
    check("long_ferr", 256'(err_cnt_a - s_err), 256'd1);
    check("long_nstb", 256'(stb_cnt_a - s_stb), 256'd0);
    frame(32'h0, 0, 1'b0);
    check("empty_ferr", 256'(err_cnt_a - s_err), 256'd0);

    // Out-of-range write and read
    frame(32'hFF12, 16, 1'b0);
    check("oor_w_regs", 256'(regs_a), 256'h003C00A500);
    check("oor_w_nstb", 256'(stb_cnt_a - s_stb), 256'd0);
    check("oor_w_ferr", 256'(err_cnt_a - s_err), 256'd0);
    frame(32'h7F00, 16, 1'b0);
    check("oor_r_miso", 256'(miso_cap), 256'h0);
    check("oor_r_oe", 256'(oe_cap), 256'h00FF);
    check("oor_r_ferr", 256'(err_cnt_a - s_err), 256'd0);

    // Reset in the middle of a write frame
    s_stb = stb_cnt_a;
    s_err = err_cnt_a;
    miso_cap = '0;
    oe_cap   = '0;
    cs_a_n = 1'b0;
    wait_cyc(HALF);
    clock_bits(32'h82, 8, 1'b0);
    rst = 1'b1;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(2);
    clock_bits(32'h77, 8, 1'b0);
    wait_cyc(HALF);
    cs_a_n = 1'b1;
    wait_cyc(3 * HALF);
    check("mid_rst_regs", 256'(regs_a), 256'h0);
    check("mid_rst_nstb", 256'(stb_cnt_a - s_stb), 256'd0);
    check("mid_rst_ferr", 256'(err_cnt_a - s_err), 256'd0);
    frame(32'h845A, 16, 1'b0);
    check("w_reg4_regs", 256'(regs_a), 256'h5A00000000);
    check("w_reg4_nstb", 256'(stb_cnt_a - s_stb), 256'd1);
    check("w_reg4_stb", 256'(stb_last_a), 256'b10000);

    // Wide instance at minimum sclk margins
    frame(32'h1FBEEF, 21, 1'b1);
    check("b_w_regs", 256'(regs_b), {16'hBEEF, 240'h0});
    check("b_w_nstb", 256'(stb_cnt_b - s_stb), 256'd1);
    check("b_w_stb", 256'(stb_last_b), 256'h8000);
    check("b_w_ferr", 256'(err_cnt_b - s_err), 256'd0);
    frame(32'h0F0000, 21, 1'b1);
    check("b_r_miso", 256'(miso_cap), 256'hBEEF);
    check("b_r_oe", 256'(oe_cap), 256'hFFFF);
    check("b_r_regs", 256'(regs_b), {16'hBEEF, 240'h0});
    check("b_r_nstb", 256'(stb_cnt_b - s_stb), 256'd0);
    check("a_untouched", 256'(regs_a), 256'h5A00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_regfile_rw.md
# spi_regfile_rw

Parametrised SPI register-file peripheral: a mode-0 SPI target that both writes and reads back a bank of `NUM_REGS` configuration registers of `DATA_W` bits. It sits between the chip's SPI pins and the design blocks that consume configuration values. It adds internal input synchronisers, read-back on `miso`, per-register write strobes and frame-error reporting. All logic runs on the system clock; SPI pins are treated as asynchronous samples.

## Interface
- `NUM_REGS`, 5, number of registers; 1..2^`ADDR_W`.
- `ADDR_W`, 7, address field width.
- `DATA_W`, 8, register/data field width.
- `SYNC_STAGES`, 2, synchroniser flops per SPI input; ≥2.
- `m_clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `sclk`  in  1  SPI clock, idle low.
- `mosi`  in  1  SPI data in.
- `cs_n`  in  1  SPI chip select, active low.
- `miso`  out  1  SPI data out.
- `miso_oe`  out  1  output enable for the `miso` pad.
- `regs`  out  `NUM_REGS*DATA_W`  register contents; reg i is at `[i*DATA_W +: DATA_W]`.
- `wr_strobe`  out  `NUM_REGS`  one-cycle pulse on the bit of the register just written.
- `frame_err`  out  1  one-cycle pulse on a discarded malformed frame.

## Operation
- Frame length is F = 1+`ADDR_W`+`DATA_W` bits, MSB first: R/W bit (1=write, 0=read), then address, then data. `mosi` is sampled on the rising edge of `sclk`.
- `sclk`, `mosi` and `cs_n` each pass through `SYNC_STAGES` flops. Edges are detected against one further registered copy.
- States: IDLE, ADDR, DATA.
  - IDLE: cs fall clears the bit counter and shift registers → ADDR.
  - ADDR: after bit 1+`ADDR_W` → DATA.
  - Any state: cs rise → IDLE.
- Bit counter saturates at F+1. Rising edges beyond F only mark the frame overlong.
- Write commit happens at cs rise when all of the following hold: count == F, R/W=1, address < `NUM_REGS`. The addressed register is updated and its `wr_strobe` bit pulses in the same cycle.
- Read:
  - On the rising edge that completes the address, `tx_shift` loads reg[addr] (0 if address ≥ `NUM_REGS`).
  - `miso` = `tx_shift` MSB.
  - `tx_shift` shifts left, zero-filled, on each falling `sclk` edge once count ≥ 1+`ADDR_W`+1.
  - A read frame never modifies registers.
- `miso_oe` = 1 from address completion of a read frame until cs rise; otherwise 0. `miso` = 0 whenever `miso_oe` = 0.
- `frame_err` pulses at cs rise when count ≠ F and count ≠ 0. An out-of-range address is not an error: the write is silently dropped and the read returns 0.
- Priority within a cycle: cs rise, then cs fall, then sclk edge. An sclk edge coinciding with a cs edge is ignored.
- `rst` asserted: all registers, counters, `tx_shift`, state and synchroniser flops go to 0, except cs synchronisers, which reset to 1. State = IDLE.
  - A frame in progress when reset releases is dropped: no write, no `frame_err`. The next cs fall starts a new frame.

## Timing
- Reset values: `regs`=0, `wr_strobe`=0, `frame_err`=0, `miso`=0, `miso_oe`=0.
- An input pin transition acts at the (`SYNC_STAGES`+1)-th `m_clk` rising edge after capture.
- Write latency: `regs` and `wr_strobe` update `SYNC_STAGES`+1 cycles after cs rise is captured.
- `miso` valid `SYNC_STAGES`+2 cycles after the triggering `sclk` edge is captured.
- Required margins:
  - `sclk` high and low phases each ≥ `SYNC_STAGES`+3 `m_clk` periods.
  - cs setup before first `sclk` rise ≥ `SYNC_STAGES`+2 periods.
  - cs hold after last `sclk` fall ≥ `SYNC_STAGES`+2 periods.
  - cs high between frames ≥ `SYNC_STAGES`+2 periods.
- `wr_strobe` and `frame_err` are high exactly one cycle per frame.

## Test plan
- Reset: assert `rst` mid-idle → `regs`=0, `miso_oe`=0. Release, then write frame 0x81,0xA5 → reg1=0xA5, `wr_strobe`=5'b00010 for one cycle.
- Read: preload reg3=0x3C, then send read frame 0x03 plus 8 clocks → `miso` sampled on rising edges = 0,0,1,1,1,1,0,0. `miso_oe` is high only after the address completes. `regs` unchanged, no strobe.
- Length errors: 15-bit write frame to reg0 → reg0 unchanged, `frame_err` one pulse. 17-bit frame → same. cs toggle with 0 clocks → no pulse.
- Out-of-range: write 0xFF,0x12 → no register change, `wr_strobe`=0, no `frame_err`. Read address 0x7F → `miso` = 0x00.
- Reset mid-frame: assert `rst` after 8 bits of a write, release, finish the clocks, raise cs → no write, no `frame_err`. The following full frame 0x84,0x5A → reg4=0x5A.
- Parameter sweep: `NUM_REGS`=16, `ADDR_W`=4, `DATA_W`=16, `SYNC_STAGES`=3. Write and read back 0xBEEF at reg15 → read returns 0xBEEF. Minimum-margin `sclk` timing still passes.
